// File: rtl/edge_detect_multi.sv
// edge_detect_multi: N_CH independent edge-detect channels.
// Each channel runs this chain:
//   synchroniser -> debounce filter -> 4-state Moore FSM -> pulse and sticky event.
// Optional feature macro EDGE_DETECT_IRQ_EN adds irq_mask/irq, a registered
// OR of the masked sticky event flags.

module edge_detect_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 3,
    parameter int PULSE_LEN   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       pulse,
    output logic       level,
    output logic       event_o,
    output logic [1:0] dbg_state
);
    localparam int FW = $clog2(FILT_CYC + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);

    typedef enum logic [1:0] {
        LOW  = 2'b00,
        RISE = 2'b01,
        HIGH = 2'b10,
        FALL = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [FW-1:0]          fcnt;
    logic [PW-1:0]          pcnt;
    logic                   pdone;
    logic                   entry;
    state_t                 state, state_n;

    assign s = sync[SYNC_STAGES-1];

    // Synchroniser chain for the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], in};
    end

    // Debounce: level follows s only after FILT_CYC consecutive mismatching cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt  <= '0;
            level <= 1'b0;
        end else if (s == level) begin
            fcnt  <= '0;
        end else if (fcnt == FW'(FILT_CYC - 1)) begin
            level <= s;
            fcnt  <= '0;
        end else begin
            fcnt  <= fcnt + 1'b1;
        end
    end

    assign pdone = (pcnt == PW'(PULSE_LEN - 1));
    assign entry = (state_n != state) && (state_n == RISE || state_n == FALL);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOW;
        else     state <= state_n;
    end

    // Next-state logic; an opposite level change aborts a running pulse
    always_comb begin
        state_n = state;
        case (state)
            LOW:  if (level) state_n = RISE;
            RISE: if (!level) state_n = FALL;
                  else if (pdone) state_n = HIGH;
            HIGH: if (!level) state_n = FALL;
            FALL: if (level) state_n = RISE;
                  else if (pdone) state_n = LOW;
            default: state_n = LOW;
        endcase
    end

    // Cycles spent in RISE/FALL; reloads on every entry so an abort restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 pcnt <= '0;
        else if (entry)                          pcnt <= '0;
        else if ((state == RISE || state == FALL) && !pdone)
                                                 pcnt <= pcnt + 1'b1;
    end

    // Moore output: state and mode only; mode 11 masks the pulse
    always_comb begin
        pulse = 1'b0;
        case (state)
            RISE:    pulse = (mode == 2'b00) || (mode == 2'b10);
            FALL:    pulse = (mode == 2'b01) || (mode == 2'b10);
            default: pulse = 1'b0;
        endcase
    end

    // Sticky event: a pulse beats a simultaneous clear so no event is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        event_o <= 1'b0;
        else if (pulse) event_o <= 1'b1;
        else if (clr)   event_o <= 1'b0;
    end

    assign dbg_state = state;
endmodule

module edge_detect_multi #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 3,
    parameter int PULSE_LEN   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     in,
    input  logic [2*N_CH-1:0]   mode,
    input  logic [N_CH-1:0]     clr,
`ifdef EDGE_DETECT_IRQ_EN
    input  logic [N_CH-1:0]     irq_mask,
    output logic                irq,
`endif
    output logic [N_CH-1:0]     pulse,
    output logic [N_CH-1:0]     level,
    output logic [N_CH-1:0]     event_o,
    output logic [2*N_CH-1:0]   dbg_state
);
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        edge_detect_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYC    (FILT_CYC),
            .PULSE_LEN   (PULSE_LEN)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .in        (in[g]),
            .mode      (mode[2*g +: 2]),
            .clr       (clr[g]),
            .pulse     (pulse[g]),
            .level     (level[g]),
            .event_o   (event_o[g]),
            .dbg_state (dbg_state[2*g +: 2])
        );
    end

`ifdef EDGE_DETECT_IRQ_EN
    // Registered interrupt: one cycle behind the masked sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= |(event_o & irq_mask);
    end
`endif
endmodule
